// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: prioritises exception flags and interrupts,
// commits one event per instruction to CP0 and holds the PC redirect until fetch takes it.
// Optional macro CP0_BYPASS_EN forwards same-cycle WB mtc0 writes into the effective CP0 view.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic        adel_mem_i,
  input  logic        ades_mem_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic        redirect_ready_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [4:0] CODE_NONE = 5'h00;
  localparam logic [4:0] CODE_INT  = 5'h01;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;
  localparam logic [4:0] CODE_ERET = 5'h0e;

  // Interrupt pending: IE set, EXL clear, and an unmasked pending line.
  function automatic logic int_pending_f(input logic [31:0] status, input logic [31:0] cause);
    int_pending_f = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;

  logic [31:0] status_e_s;
  logic [31:0] cause_e_s;
  logic [31:0] epc_e_s;
  logic        int_p_s;

  logic [4:0]  exc_code_s;
  logic [31:0] exc_bad_s;
  logic        exc_eret_s;
  logic        detect_s;

  logic [31:0] excepttype_nxt_s;
  logic [31:0] inst_addr_nxt_s;
  logic        delayslot_nxt_s;
  logic [31:0] bad_addr_nxt_s;
  logic        flush_nxt_s;
  logic        redirect_valid_nxt_s;
  logic [31:0] new_pc_nxt_s;
  logic        busy_nxt_s;

  logic [31:0] excepttype_r;
  logic [31:0] inst_addr_r;
  logic        delayslot_r;
  logic [31:0] bad_addr_r;
  logic        flush_r;
  logic        redirect_valid_r;
  logic [31:0] new_pc_r;
  logic        busy_r;

  logic        unused_s;

`ifdef CP0_BYPASS_EN
  // Effective CP0 view with same-cycle WB mtc0 forwarding (cause: only the software IP bits).
  always_comb begin
    status_e_s = status_i;
    cause_e_s  = cause_i;
    epc_e_s    = epc_i;
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd12)) begin
      status_e_s = wb_cp0_data_i;
    end else begin
      status_e_s = status_i;
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd13)) begin
      cause_e_s = {cause_i[31:10], wb_cp0_data_i[9:8], cause_i[7:0]};
    end else begin
      cause_e_s = cause_i;
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd14)) begin
      epc_e_s = wb_cp0_data_i;
    end else begin
      epc_e_s = epc_i;
    end
  end

  assign unused_s = ^{status_e_s[31:16], status_e_s[7:2], cause_e_s[31:16], cause_e_s[7:0]};
`else
  // Effective CP0 view is the registered CP0 state; mtc0 takes effect a cycle later.
  always_comb begin
    status_e_s = status_i;
    cause_e_s  = cause_i;
    epc_e_s    = epc_i;
  end

  assign unused_s = ^{status_e_s[31:16], status_e_s[7:2], cause_e_s[31:16], cause_e_s[7:0],
                      wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i};
`endif

  assign int_p_s = int_pending_f(status_e_s, cause_e_s);

  // Priority encoder over interrupt and per-instruction exception flags.
  always_comb begin
    exc_code_s = CODE_NONE;
    exc_bad_s  = 32'd0;
    exc_eret_s = 1'b0;
    if (int_p_s) begin
      exc_code_s = CODE_INT;
    end else if (adel_if_i) begin
      exc_code_s = CODE_ADEL;
      exc_bad_s  = pc_i;
    end else if (ri_i) begin
      exc_code_s = CODE_RI;
    end else if (ov_i) begin
      exc_code_s = CODE_OV;
    end else if (syscall_i) begin
      exc_code_s = CODE_SYS;
    end else if (break_i) begin
      exc_code_s = CODE_BP;
    end else if (adel_mem_i) begin
      exc_code_s = CODE_ADEL;
      exc_bad_s  = mem_addr_i;
    end else if (ades_mem_i) begin
      exc_code_s = CODE_ADES;
      exc_bad_s  = mem_addr_i;
    end else if (eret_i) begin
      exc_code_s = CODE_ERET;
      exc_eret_s = 1'b1;
    end else begin
      exc_code_s = CODE_NONE;
    end
  end

  // A bubble never commits, so a pending interrupt waits for a real instruction.
  assign detect_s = (state_r == ST_IDLE) && inst_valid_i && (exc_code_s != CODE_NONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (detect_s) begin
          state_nxt_s = ST_COMMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (redirect_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle; commit fields live only in the COMMIT cycle.
  always_comb begin
    excepttype_nxt_s     = 32'd0;
    inst_addr_nxt_s      = 32'd0;
    delayslot_nxt_s      = 1'b0;
    bad_addr_nxt_s       = 32'd0;
    flush_nxt_s          = 1'b0;
    redirect_valid_nxt_s = (state_nxt_s != ST_IDLE);
    busy_nxt_s           = (state_nxt_s != ST_IDLE);
    new_pc_nxt_s         = new_pc_r;
    if (detect_s) begin
      excepttype_nxt_s = {27'd0, exc_code_s};
      inst_addr_nxt_s  = pc_i;
      delayslot_nxt_s  = is_in_delayslot_i;
      bad_addr_nxt_s   = exc_bad_s;
      flush_nxt_s      = 1'b1;
      new_pc_nxt_s     = exc_eret_s ? epc_e_s : EXC_VECTOR;
    end else if (state_nxt_s == ST_IDLE) begin
      new_pc_nxt_s = 32'd0;
    end else begin
      new_pc_nxt_s = new_pc_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      excepttype_r     <= 32'd0;
      inst_addr_r      <= 32'd0;
      delayslot_r      <= 1'b0;
      bad_addr_r       <= 32'd0;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      new_pc_r         <= 32'd0;
      busy_r           <= 1'b0;
    end else begin
      excepttype_r     <= excepttype_nxt_s;
      inst_addr_r      <= inst_addr_nxt_s;
      delayslot_r      <= delayslot_nxt_s;
      bad_addr_r       <= bad_addr_nxt_s;
      flush_r          <= flush_nxt_s;
      redirect_valid_r <= redirect_valid_nxt_s;
      new_pc_r         <= new_pc_nxt_s;
      busy_r           <= busy_nxt_s;
    end
  end

  assign excepttype_o        = excepttype_r;
  assign current_inst_addr_o = inst_addr_r;
  assign is_in_delayslot_o   = delayslot_r;
  assign bad_addr_o          = bad_addr_r;
  assign flush_o             = flush_r;
  assign redirect_valid_o    = redirect_valid_r;
  assign new_pc_o            = new_pc_r;
  assign busy_o              = busy_r;

endmodule

// Protocol invariants of the exception interface outputs.
module exc_ctrl_chk (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  input logic        redirect_valid,
  input logic        busy,
  input logic [31:0] excepttype
);

  a_flush_redirect: assert property (@(posedge clk) disable iff (rst) flush |-> (redirect_valid && busy));
  a_flush_single:   assert property (@(posedge clk) disable iff (rst) flush |=> !flush);
  a_busy_redirect:  assert property (@(posedge clk) disable iff (rst) busy == redirect_valid);
  a_code_flush:     assert property (@(posedge clk) disable iff (rst) (excepttype != 32'd0) |-> flush);

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomised and directed bench for exc_ctrl against a transaction-level reference model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i, wb_cp0_data_i;
  logic        adel_if_i, ri_i, ov_i, syscall_i, break_i, eret_i, adel_mem_i, ades_mem_i;
  logic        wb_cp0_we_i, redirect_ready_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, redirect_valid_o, busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: an outstanding redirect and its target.
  bit          ref_busy;
  logic [31:0] ref_target;
  logic [31:0] exp_type, exp_addr, exp_bad, exp_pc;
  logic        exp_ds, exp_flush, exp_rv, exp_busy;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i),
    .syscall_i(syscall_i), .break_i(break_i), .eret_i(eret_i), .adel_mem_i(adel_mem_i),
    .ades_mem_i(ades_mem_i), .mem_addr_i(mem_addr_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_data_i(wb_cp0_data_i), .redirect_ready_i(redirect_ready_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  exc_ctrl_chk chk (
    .clk(clk), .rst(rst), .flush(flush_o), .redirect_valid(redirect_valid_o),
    .busy(busy_o), .excepttype(excepttype_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Priority table walk: first asserted condition wins.
  task automatic ref_event(output bit hit, output logic [31:0] code, output logic [31:0] bad,
                           output logic [31:0] target);
    logic [31:0] st, ca, ep;
    bit          cond [9];
    int          codes [9] = '{1, 4, 10, 12, 8, 9, 4, 5, 14};
    st = status_i; ca = cause_i; ep = epc_i;
`ifdef CP0_BYPASS_EN
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ep = wb_cp0_data_i;
`endif
    cond[0] = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
    cond[1] = adel_if_i;  cond[2] = ri_i;     cond[3] = ov_i;
    cond[4] = syscall_i;  cond[5] = break_i;  cond[6] = adel_mem_i;
    cond[7] = ades_mem_i; cond[8] = eret_i;
    hit = 1'b0; code = 32'd0; bad = 32'd0; target = 32'hBFC00380;
    for (int i = 0; i < 9; i++) begin
      if (!hit && cond[i]) begin
        hit  = 1'b1;
        code = codes[i];
        if (i == 1) bad = pc_i;
        if (i == 6 || i == 7) bad = mem_addr_i;
        if (i == 8) target = ep;
      end
    end
  endtask

  // Expected outputs after the coming clock edge, from the current inputs.
  task automatic ref_update();
    bit          hit;
    logic [31:0] code, bad, target;
    exp_type = 32'd0; exp_addr = 32'd0; exp_bad = 32'd0; exp_ds = 1'b0;
    exp_flush = 1'b0; exp_rv = 1'b0; exp_busy = 1'b0; exp_pc = 32'd0;
    if (rst) begin
      ref_busy = 1'b0;
    end else if (!ref_busy) begin
      ref_event(hit, code, bad, target);
      if (inst_valid_i && hit) begin
        ref_busy = 1'b1; ref_target = target;
        exp_type = code; exp_addr = pc_i; exp_bad = bad; exp_ds = is_in_delayslot_i;
        exp_flush = 1'b1; exp_rv = 1'b1; exp_busy = 1'b1; exp_pc = target;
      end
    end else if (redirect_ready_i) begin
      ref_busy = 1'b0;
    end else begin
      exp_rv = 1'b1; exp_busy = 1'b1; exp_pc = ref_target;
    end
  endtask

  task automatic check_all();
    check_val("excepttype", excepttype_o, exp_type);
    check_val("inst_addr", current_inst_addr_o, exp_addr);
    check_val("delayslot", {31'd0, is_in_delayslot_o}, {31'd0, exp_ds});
    check_val("bad_addr", bad_addr_o, exp_bad);
    check_val("flush", {31'd0, flush_o}, {31'd0, exp_flush});
    check_val("redirect_valid", {31'd0, redirect_valid_o}, {31'd0, exp_rv});
    check_val("busy", {31'd0, busy_o}, {31'd0, exp_busy});
    if (exp_rv) check_val("new_pc", new_pc_o, exp_pc);
  endtask

  task automatic cycle();
    ref_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    rst = 1'b0; inst_valid_i = 1'b0; pc_i = 32'd0; is_in_delayslot_i = 1'b0;
    adel_if_i = 1'b0; ri_i = 1'b0; ov_i = 1'b0; syscall_i = 1'b0; break_i = 1'b0;
    eret_i = 1'b0; adel_mem_i = 1'b0; ades_mem_i = 1'b0; mem_addr_i = 32'd0;
    status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0; wb_cp0_we_i = 1'b0;
    wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'd0; redirect_ready_i = 1'b1;
  endtask

  task automatic randomize_inputs();
    logic [4:0] addrs [4] = '{5'd12, 5'd13, 5'd14, 5'd3};
    rst = ($urandom_range(63) == 0);
    inst_valid_i = ($urandom_range(3) != 0);
    pc_i = {$urandom} & 32'hFFFFFFFC;
    is_in_delayslot_i = $urandom_range(1);
    adel_if_i = ($urandom_range(15) == 0); ri_i = ($urandom_range(15) == 0);
    ov_i = ($urandom_range(15) == 0);      syscall_i = ($urandom_range(15) == 0);
    break_i = ($urandom_range(15) == 0);   eret_i = ($urandom_range(7) == 0);
    adel_mem_i = ($urandom_range(15) == 0); ades_mem_i = ($urandom_range(15) == 0);
    mem_addr_i = $urandom;
    status_i = $urandom & 32'h0000FF03;
    cause_i = ($urandom_range(3) == 0) ? ($urandom & 32'h0000FF00) : 32'd0;
    epc_i = $urandom;
    wb_cp0_we_i = ($urandom_range(3) == 0);
    wb_cp0_waddr_i = addrs[$urandom_range(3)];
    wb_cp0_data_i = $urandom;
    redirect_ready_i = $urandom_range(1);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    clear_inputs();
    cycle();

    // syscall with immediate redirect acceptance
    syscall_i = 1'b1; inst_valid_i = 1'b1; pc_i = 32'hBFC00100;
    cycle();
    clear_inputs();
    cycle();
    cycle();

    // ades in a delay slot
    ades_mem_i = 1'b1; inst_valid_i = 1'b1; mem_addr_i = 32'h00001003;
    is_in_delayslot_i = 1'b1; pc_i = 32'h80000040;
    cycle();
    clear_inputs();
    cycle();

    // eret with fetch stalled for three cycles
    eret_i = 1'b1; inst_valid_i = 1'b1; epc_i = 32'hBFC00200; pc_i = 32'h80000100;
    cycle();
    redirect_ready_i = 1'b0;
    repeat (3) cycle();
    redirect_ready_i = 1'b1;
    cycle();
    clear_inputs();
    cycle();

    // interrupt beats ri; with EXL set ri is taken
    status_i = 32'h0000FF01; cause_i = 32'h00000400; ri_i = 1'b1; inst_valid_i = 1'b1;
    pc_i = 32'h80000200;
    cycle();
    clear_inputs();
    cycle();
    status_i = 32'h0000FF03; cause_i = 32'h00000400; ri_i = 1'b1; inst_valid_i = 1'b1;
    cycle();
    clear_inputs();
    cycle();

    // interrupt on a bubble is deferred
    status_i = 32'h0000FF01; cause_i = 32'h00000400; inst_valid_i = 1'b0;
    cycle();
    inst_valid_i = 1'b1; pc_i = 32'h80000300;
    cycle();
    clear_inputs();
    cycle();

    // mtc0 status in WB together with a pending IP
    cause_i = 32'h00000100; inst_valid_i = 1'b1; wb_cp0_we_i = 1'b1;
    wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h00000101;
    cycle();
    clear_inputs();
    cycle();

    // reset while waiting, then a fresh syscall
    break_i = 1'b1; inst_valid_i = 1'b1; pc_i = 32'h80000400; redirect_ready_i = 1'b0;
    cycle();
    clear_inputs(); redirect_ready_i = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    clear_inputs();
    syscall_i = 1'b1; inst_valid_i = 1'b1; pc_i = 32'h80000500;
    cycle();
    clear_inputs();
    cycle();

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- MEM-stage exception controller; the producer side of the CP0 exception interface.
- Collects per-instruction exception flags and pending interrupts, prioritises them, and emits a one-cycle exception commit (type, PC, delay-slot bit, bad address) to CP0.
- Asserts a pipeline flush and holds a PC redirect (exception vector or EPC for eret) until fetch accepts it.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except eret.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_valid_i  in  1  MEM holds a real (non-bubble) instruction
- pc_i  in  32  MEM instruction address
- is_in_delayslot_i  in  1  MEM instruction is in a delay slot
- adel_if_i, ri_i, ov_i, syscall_i, break_i, eret_i, adel_mem_i, ades_mem_i  in  1 each  exception flags carried down the pipe
- mem_addr_i  in  32  data access address
- status_i, cause_i, epc_i  in  32  current CP0 register values
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable
- wb_cp0_waddr_i  in  5  WB mtc0 register number (12 status, 13 cause, 14 epc)
- wb_cp0_data_i  in  32  WB mtc0 data
- redirect_ready_i  in  1  fetch accepts the redirect
- excepttype_o  out  32  exception code to CP0
- current_inst_addr_o  out  32  faulting PC to CP0
- is_in_delayslot_o  out  1  delay-slot bit to CP0
- bad_addr_o  out  32  BadVAddr value to CP0
- flush_o  out  1  flush IF..MEM
- redirect_valid_o  out  1  new_pc_o valid
- new_pc_o  out  32  redirect target
- busy_o  out  1  controller not IDLE; upstream stalls

Behaviour:
- Reset: all outputs 0, state IDLE.
- Effective regs: status_e/cause_e/epc_e equal the inputs.
  - With CP0_BYPASS_EN, a same-cycle WB write replaces them: status full word; cause bits [9:8] only; epc full word.
- Interrupt pending (int_p): status_e[0]=1, status_e[1]=0, and (cause_e[15:8] & status_e[15:8]) != 0.
- Detection is combinational and runs only in IDLE with inst_valid_i=1. Priority and code, highest first:
  - int_p -> 0x1
  - adel_if_i -> 0x4, bad_addr=pc_i
  - ri_i -> 0xa
  - ov_i -> 0xc
  - syscall_i -> 0x8
  - break_i -> 0x9
  - adel_mem_i -> 0x4, bad_addr=mem_addr_i
  - ades_mem_i -> 0x5, bad_addr=mem_addr_i
  - eret_i -> 0xe
  - Nothing pending -> no action.
- Bad address: cases without a bad address latch bad_addr_o=0.
- States:
  - IDLE: on detection at cycle T, latch code, pc_i, delay-slot bit and bad address; latch target = epc_e if eret, else EXC_VECTOR; go to COMMIT.
  - COMMIT (cycle T+1, exactly one cycle): excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o driven from latches; flush_o=1; redirect_valid_o=1.
    - redirect_ready_i=1 -> IDLE.
    - Otherwise -> WAIT.
  - WAIT: excepttype_o=0, flush_o=0; redirect_valid_o held at 1 with new_pc_o stable; go to IDLE on redirect_ready_i.
- Outside COMMIT, excepttype_o, current_inst_addr_o, is_in_delayslot_o and bad_addr_o are 0.
- busy_o=1 in COMMIT and WAIT.
- inst_valid_i and all flags are ignored outside IDLE: the instruction is flushed and is not re-detected.
- Interrupt taken with no valid instruction (bubble): deferred until inst_valid_i=1.
- EPC and the delay-slot adjustment (PC-4) are CP0's job. This block passes pc_i unmodified.
- rst in COMMIT or WAIT: IDLE next cycle, all outputs 0, latched event discarded.

Optional Feature:
- Macro CP0_BYPASS_EN.
- Defined: WB mtc0 to status/cause/epc forwards into int_p and eret target in the same cycle. Example: mtc0 status IE=1 in WB together with a pending IP in MEM -> interrupt taken at once.
- Undefined: status_i/cause_i/epc_i are used as-is. The wb_cp0_* inputs are unused; the effect of mtc0 is seen one cycle later.

Test Plan:
- syscall_i=1, pc_i=0xBFC00100, delay slot 0, redirect_ready_i=1 -> next cycle: excepttype_o=0x8, current_inst_addr_o=0xBFC00100, flush_o=1, new_pc_o=0xBFC00380; IDLE the cycle after.
- ades_mem_i=1, mem_addr_i=0x00001003, delay slot 1 -> excepttype_o=0x5, bad_addr_o=0x00001003, is_in_delayslot_o=1.
- eret_i=1, epc_i=0xBFC00200, redirect_ready_i=0 for 3 cycles:
  - flush_o high for 1 cycle only.
  - redirect_valid_o high for 4 cycles with new_pc_o=0xBFC00200.
  - busy_o high throughout.
- status_i=0x0000FF01, cause_i=0x00000400, ri_i=1 -> interrupt wins: excepttype_o=0x1. Repeat with status_i[1]=1 -> excepttype_o=0xa.
- CP0_BYPASS_EN defined: status_i=0, cause_i=0x00000100, WB mtc0 status=0x00000101 -> excepttype_o=0x1. Undefined: no exception that cycle.
- rst asserted during WAIT -> next cycle all outputs 0; a new syscall afterward commits normally.
